// File: rtl/delay_req_pkg.sv
// Shared definitions for the delay requester: FSM state encoding and
// default timing parameters.
package delay_req_pkg;

  localparam int WCNT_W        = 5;
  localparam int RCNT_W        = 2;
  localparam int TIMEOUT_DEF   = 16;
  localparam int MAX_RETRY_DEF = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_OK    = 3'd3,
    ST_FAIL  = 3'd4
  } state_t;

endpackage

// File: rtl/req_wait_timer.sv
// Wait-cycle counter for one attempt: loads 1 when the attempt is issued,
// counts up while waiting and flags the terminal count at TIMEOUT.
module req_wait_timer
  import delay_req_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_inc,
  output logic [WCNT_W-1:0] o_wcnt,
  output logic              o_tc
);

  localparam logic [WCNT_W-1:0] TIMEOUT_L = WCNT_W'(TIMEOUT);

  logic [WCNT_W-1:0] r_wcnt;

  // Counter never passes TIMEOUT because the FSM stops incrementing at tc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wcnt <= {WCNT_W{1'b0}};
    end else if (i_load) begin
      r_wcnt <= {{(WCNT_W-1){1'b0}}, 1'b1};
    end else if (i_inc) begin
      r_wcnt <= r_wcnt + {{(WCNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_wcnt <= r_wcnt;
    end
  end

  assign o_wcnt = r_wcnt;
  assign o_tc   = (r_wcnt == TIMEOUT_L);

endmodule

// File: rtl/delay_requester.sv
// Issues a start pulse to a delay unit, waits for its done pulse with a
// per-attempt timeout, re-issues on timeout and reports ok/fail.
module delay_requester
  import delay_req_pkg::*;
#(
  parameter int TIMEOUT   = TIMEOUT_DEF,
  parameter int MAX_RETRY = MAX_RETRY_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  output logic        start_o,
  input  logic        done_i,
  output logic        busy_o,
  output logic        ok_o,
  output logic        fail_o,
  output logic [4:0]  latency_o,
  output logic [1:0]  retries_o,
  output logic        spur_o
);

  localparam logic [RCNT_W-1:0] MAX_RETRY_L = RCNT_W'(MAX_RETRY);

  state_t            r_state;
  logic [RCNT_W-1:0] r_rcnt;
  logic              r_start;
  logic              r_busy;
  logic              r_ok;
  logic              r_fail;
  logic              r_spur;
  logic [WCNT_W-1:0] r_latency;
  logic [RCNT_W-1:0] r_retries;

  logic [WCNT_W-1:0] w_wcnt;
  logic              w_tc;
  logic              w_load;
  logic              w_inc;

  assign w_load = (r_state == ST_ISSUE);
  assign w_inc  = (r_state == ST_WAIT) && !done_i && !w_tc;

  req_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_inc  (w_inc),
    .o_wcnt (w_wcnt),
    .o_tc   (w_tc)
  );

  // Control FSM; every output is set on the edge entering its state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_rcnt    <= {RCNT_W{1'b0}};
      r_start   <= 1'b0;
      r_busy    <= 1'b0;
      r_ok      <= 1'b0;
      r_fail    <= 1'b0;
      r_spur    <= 1'b0;
      r_latency <= {WCNT_W{1'b0}};
      r_retries <= {RCNT_W{1'b0}};
    end else begin
      r_start <= 1'b0;
      r_ok    <= 1'b0;
      r_fail  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_i) begin
            r_state <= ST_ISSUE;
            r_rcnt  <= {RCNT_W{1'b0}};
            r_start <= 1'b1;
            r_busy  <= 1'b1;
            // A done coinciding with the new request still counts as spurious.
            r_spur  <= done_i;
          end else begin
            r_state <= ST_IDLE;
            r_spur  <= r_spur | done_i;
          end
        end
        ST_ISSUE: begin
          r_state <= ST_WAIT;
          r_spur  <= r_spur | done_i;
        end
        ST_WAIT: begin
          if (done_i) begin
            r_state   <= ST_OK;
            r_ok      <= 1'b1;
            r_latency <= w_wcnt;
            r_retries <= r_rcnt;
          end else if (w_tc) begin
            if (r_rcnt < MAX_RETRY_L) begin
              r_state <= ST_ISSUE;
              r_start <= 1'b1;
              r_rcnt  <= r_rcnt + {{(RCNT_W-1){1'b0}}, 1'b1};
            end else begin
              r_state   <= ST_FAIL;
              r_fail    <= 1'b1;
              r_retries <= r_rcnt;
            end
          end else begin
            r_state <= ST_WAIT;
          end
        end
        ST_OK, ST_FAIL: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_spur  <= r_spur | done_i;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign start_o   = r_start;
  assign busy_o    = r_busy;
  assign ok_o      = r_ok;
  assign fail_o    = r_fail;
  assign spur_o    = r_spur;
  assign latency_o = r_latency;
  assign retries_o = r_retries;

endmodule

// File: tb/tb_delay_requester.sv
// Directed bench for delay_requester: nominal response, full timeout,
// retry success, boundary latency, back-to-back requests, spurious done, reset.
module tb_delay_requester;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_i;
  logic       start_o;
  logic       done_i;
  logic       busy_o;
  logic       ok_o;
  logic       fail_o;
  logic [4:0] latency_o;
  logic [1:0] retries_o;
  logic       spur_o;

  int n_checks   = 0;
  int n_failures = 0;
  int cyc        = 0;
  int n_start    = 0;
  int n_ok       = 0;
  int n_failp    = 0;
  int n_both     = 0;
  int ok_cyc     = 0;
  int fail_cyc   = 0;
  int start_cyc [8];
  int saved_ok;
  int saved_fail;
  bit got;

  delay_requester #(
    .TIMEOUT   (16),
    .MAX_RETRY (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .start_o   (start_o),
    .done_i    (done_i),
    .busy_o    (busy_o),
    .ok_o      (ok_o),
    .fail_o    (fail_o),
    .latency_o (latency_o),
    .retries_o (retries_o),
    .spur_o    (spur_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and log output pulses seen there.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (start_o === 1'b1) begin
      if (n_start < 8) start_cyc[n_start] = cyc;
      n_start++;
    end
    if (ok_o === 1'b1) begin
      n_ok++;
      ok_cyc = cyc;
    end
    if (fail_o === 1'b1) begin
      n_failp++;
      fail_cyc = cyc;
    end
    if (ok_o === 1'b1 && fail_o === 1'b1) n_both++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst    = 1'b1;
    req_i  = 1'b0;
    done_i = 1'b0;
    ticks(3);
    check("reset_outputs", {start_o, busy_o, ok_o, fail_o, latency_o, retries_o, spur_o}, 12'd0);
    rst = 1'b0;
    tick();
    check("idle_busy", busy_o, 1'b0);

    // Nominal: delay unit answers in WAIT cycle 10.
    n_start = 0;
    req_i = 1'b1;
    tick();
    check("t1_start", start_o, 1'b1);
    check("t1_busy", busy_o, 1'b1);
    req_i = 1'b0;
    ticks(10);
    check("t1_no_ok_yet", ok_o, 1'b0);
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    check("t1_ok", ok_o, 1'b1);
    check("t1_latency", latency_o, 5'd10);
    check("t1_retries", retries_o, 2'd0);
    tick();
    check("t1_ok_single", ok_o, 1'b0);
    check("t1_idle", busy_o, 1'b0);
    check("t1_one_start", n_start, 32'd1);

    // Delay unit never responds: four attempts then fail.
    n_start = 0;
    saved_ok = n_ok;
    req_i = 1'b1;
    tick();
    req_i = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 120 && !got; i++) begin
      tick();
      if (fail_o === 1'b1 || ok_o === 1'b1) got = 1'b1;
    end
    check("t2_terminated", got, 1'b1);
    check("t2_fail", fail_o, 1'b1);
    check("t2_starts", n_start, 32'd4);
    check("t2_gap01", start_cyc[1] - start_cyc[0], 32'd17);
    check("t2_gap12", start_cyc[2] - start_cyc[1], 32'd17);
    check("t2_gap23", start_cyc[3] - start_cyc[2], 32'd17);
    check("t2_fail_time", fail_cyc - start_cyc[3], 32'd17);
    check("t2_retries", retries_o, 2'd3);
    check("t2_latency_held", latency_o, 5'd10);
    check("t2_no_ok", n_ok - saved_ok, 32'd0);
    tick();
    check("t2_fail_single", fail_o, 1'b0);
    check("t2_idle", busy_o, 1'b0);

    // First attempt dropped, second answered in WAIT cycle 5.
    n_start = 0;
    req_i = 1'b1;
    tick();
    req_i = 1'b0;
    for (int i = 0; i < 30 && n_start < 2; i++) tick();
    check("t3_reissue", n_start, 32'd2);
    check("t3_gap", start_cyc[1] - start_cyc[0], 32'd17);
    ticks(5);
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    check("t3_ok", ok_o, 1'b1);
    check("t3_latency", latency_o, 5'd5);
    check("t3_retries", retries_o, 2'd1);
    tick();

    // Done exactly at wcnt == TIMEOUT wins over the timeout.
    n_start = 0;
    req_i = 1'b1;
    tick();
    req_i = 1'b0;
    ticks(16);
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    check("t4_ok", ok_o, 1'b1);
    check("t4_latency", latency_o, 5'd16);
    check("t4_retries", retries_o, 2'd0);
    ticks(3);
    check("t4_no_reissue", n_start, 32'd1);

    // Held request with done in first WAIT cycle; restart two cycles after ok.
    n_start = 0;
    req_i = 1'b1;
    tick();
    tick();
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    check("t5_ok", ok_o, 1'b1);
    check("t5_latency", latency_o, 5'd1);
    ticks(2);
    check("t5_restart", start_o, 1'b1);
    check("t5_restart_gap", start_cyc[1] - ok_cyc, 32'd2);
    req_i = 1'b0;
    tick();
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    tick();
    check("t5_spur_clear", spur_o, 1'b0);

    // Spurious done in IDLE.
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    tick();
    check("t6_spur_set", spur_o, 1'b1);
    check("t6_stay_idle", busy_o, 1'b0);
    check("t6_no_start", start_o, 1'b0);
    req_i = 1'b1;
    tick();
    req_i = 1'b0;
    check("t6_spur_cleared", spur_o, 1'b0);
    check("t6_started", start_o, 1'b1);
    tick();
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    tick();

    // Reset in the middle of WAIT, then a late done.
    saved_ok   = n_ok;
    saved_fail = n_failp;
    req_i = 1'b1;
    tick();
    req_i = 1'b0;
    ticks(3);
    rst = 1'b1;
    #1;
    check("t7_reset_outputs", {start_o, busy_o, ok_o, fail_o, latency_o, retries_o, spur_o}, 12'd0);
    ticks(2);
    rst = 1'b0;
    tick();
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    tick();
    check("t7_late_spur", spur_o, 1'b1);
    check("t7_idle", busy_o, 1'b0);
    ticks(20);
    check("t7_no_ok", n_ok - saved_ok, 32'd0);
    check("t7_no_fail", n_failp - saved_fail, 32'd0);
    check("ok_fail_exclusive", n_both, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule
